// File: rtl/scr1_tb_add_cmd_gen_pkg.sv
// Shared constants, FSM state type and instruction encoders for the
// ADD/ADDI command generator.
package scr1_tb_add_gen_pkg;

    localparam logic [6:0]  OP_REG     = 7'b0110011;
    localparam logic [6:0]  OP_IMM     = 7'b0010011;
    localparam logic [2:0]  FUNCT3_ADD = 3'b000;
    localparam logic [6:0]  FUNCT7_ADD = 7'b0000000;
    localparam logic [6:0]  FUNCT7_SUB = 7'b0100000;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN,
        DONE
    } type_scr1_add_gen_fsm_e;

    function automatic logic [31:0] enc_r_type(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] funct3,
        input logic [4:0] rd,
        input logic [6:0] opcode
    );
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

    function automatic logic [31:0] enc_i_type(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  funct3,
        input logic [4:0]  rd,
        input logic [6:0]  opcode
    );
        return {imm, rs1, funct3, rd, opcode};
    endfunction

endpackage

// File: rtl/scr1_tb_add_cmd_gen_if.sv
// Instruction offer channel between the generator and the TB loader / IFU stub.
// Optional macro SCR1_TB_ADD_GEN_SUB_EN adds the is_sub_o flag.
interface scr1_tb_add_cmd_gen_if;

    logic [31:0] instr_o;
    logic        instr_vld_o;
    logic        instr_rdy_i;
    logic [4:0]  exp_rd_addr_o;
    logic [31:0] exp_rd_data_o;
`ifdef SCR1_TB_ADD_GEN_SUB_EN
    logic        is_sub_o;
`endif

    modport master (
        output instr_o,
        output instr_vld_o,
        output exp_rd_addr_o,
        output exp_rd_data_o,
`ifdef SCR1_TB_ADD_GEN_SUB_EN
        output is_sub_o,
`endif
        input  instr_rdy_i
    );

    modport slave (
        input  instr_o,
        input  instr_vld_o,
        input  exp_rd_addr_o,
        input  exp_rd_data_o,
`ifdef SCR1_TB_ADD_GEN_SUB_EN
        input  is_sub_o,
`endif
        output instr_rdy_i
    );

endinterface

// File: rtl/scr1_tb_add_cmd_gen_lfsr32.sv
// 32-bit right-shifting Galois LFSR; advances only when step_i is high.
module scr1_tb_lfsr32
    import scr1_tb_add_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    output logic [31:0] value_o
);

    // An all-zero state would lock up, so a zero seed becomes 1.
    localparam logic [31:0] RST_VAL = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next LFSR value: shift right, fold taps in when the outgoing bit is set.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= RST_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/scr1_tb_add_cmd_gen.sv
// ADD instruction stream generator: seeds x1..x31 with ADDI, then emits
// LFSR-driven ADD words with the expected rd value from a shadow regfile.
// Optional macro SCR1_TB_ADD_GEN_SUB_EN: sel bit turns RUN words into SUB.
module scr1_tb_add_cmd_gen
    import scr1_tb_add_gen_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      num_cmd_i,
    scr1_tb_add_cmd_gen_if.master cmd_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      cmd_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    type_scr1_add_gen_fsm_e state_q, state_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       tgt_q, tgt_d;
    logic [4:0]             seed_idx_q, seed_idx_d;
    logic [31:0]            shadow_q [0:31];
    logic [31:0]            shadow_d [0:31];

    logic [31:0] lfsr;
    logic        xfer;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [11:0] f_imm;
    logic [31:0] imm_sext;
    logic [31:0] op1, op2;
    logic [31:0] word_instr;
    logic [4:0]  word_rd;
    logic [31:0] word_data;
    logic        word_sub;
    logic        lfsr_unused;

    assign xfer = vld_q & cmd_if.instr_rdy_i;

    scr1_tb_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_i  (xfer),
        .value_o (lfsr)
    );

    assign f_rd     = lfsr[4:0];
    assign f_rs1    = lfsr[9:5];
    assign f_rs2    = lfsr[14:10];
    assign f_imm    = lfsr[26:15];
    assign imm_sext = {{20{f_imm[11]}}, f_imm};
    assign op1      = (f_rs1 == 5'd0) ? '0 : shadow_q[f_rs1];
    assign op2      = (f_rs2 == 5'd0) ? '0 : shadow_q[f_rs2];

`ifdef SCR1_TB_ADD_GEN_SUB_EN
    assign lfsr_unused = ^lfsr[30:27];
`else
    assign lfsr_unused = ^lfsr[31:27];
`endif

    // Decode the word on offer from the current LFSR value and shadow regs.
    always_comb begin
        word_instr = '0;
        word_rd    = '0;
        word_data  = '0;
        word_sub   = 1'b0;
        if (state_q == SEED) begin
            word_instr = enc_i_type(f_imm, 5'd0, FUNCT3_ADD, seed_idx_q, OP_IMM);
            word_rd    = seed_idx_q;
            word_data  = imm_sext;
        end else if (state_q == RUN) begin
`ifdef SCR1_TB_ADD_GEN_SUB_EN
            word_sub   = lfsr[31];
`endif
            word_instr = enc_r_type(word_sub ? FUNCT7_SUB : FUNCT7_ADD,
                                    f_rs2, f_rs1, FUNCT3_ADD, f_rd, OP_REG);
            word_rd    = f_rd;
            if (f_rd != 5'd0) begin
                word_data = word_sub ? (op1 - op2) : (op1 + op2);
            end
        end
    end

    // FSM next state, counters and shadow register update on transfer.
    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        seed_idx_d = seed_idx_q;
        shadow_d   = shadow_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = SEED;
                    tgt_d      = num_cmd_i;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    vld_d      = 1'b0;
                    seed_idx_d = 5'd1;
                end
            end
            SEED: begin
                vld_d = 1'b1;
                if (xfer) begin
                    shadow_d[seed_idx_q] = word_data;
                    seed_idx_d           = seed_idx_q + 5'd1;
                    if (seed_idx_q == 5'd31) begin
                        if (tgt_q == '0) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (f_rd != 5'd0) begin
                        shadow_d[f_rd] = word_data;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (cnt_q == (tgt_q - CNT_ONE)) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            tgt_q      <= '0;
            seed_idx_q <= 5'd1;
            shadow_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            seed_idx_q <= seed_idx_d;
            shadow_q   <= shadow_d;
        end
    end

    // Word fields are forced to zero whenever nothing is on offer.
    assign cmd_if.instr_vld_o   = vld_q;
    assign cmd_if.instr_o       = vld_q ? word_instr : '0;
    assign cmd_if.exp_rd_addr_o = vld_q ? word_rd    : '0;
    assign cmd_if.exp_rd_data_o = vld_q ? word_data  : '0;
`ifdef SCR1_TB_ADD_GEN_SUB_EN
    assign cmd_if.is_sub_o      = vld_q & word_sub;
`endif
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cmd_cnt_o = cnt_q;

endmodule
